// File: rtl/irrigacao_ctrl.sv
// Irrigation and reservoir controller: debounced probe/soil/temperature inputs,
// an inlet-valve FSM with hysteresis and fill timeout, and a drip/sprinkler FSM.
module irrigacao_ctrl #(
    parameter int LEVELS       = 3,
    parameter int DEB_CYCLES   = 4,
    parameter int LOW_MARK     = 1,
    parameter int SPRAY_MIN    = 2,
    parameter int FILL_TIMEOUT = 256,
    parameter int MIN_ON       = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [LEVELS-1:0]            level_i,
    input  logic [1:0]                   soil_i,
    input  logic                         temp_hi_i,
    input  logic                         fault_clr_i,
    output logic                         valve_in_o,
    output logic                         drip_o,
    output logic                         sprinkler_o,
    output logic                         alarm_o,
    output logic                         err_level_o,
    output logic                         err_soil_o,
    output logic                         fill_fault_o,
    output logic [$clog2(LEVELS+1)-1:0]  level_count_o
);

    localparam int NB  = LEVELS + 3;
    localparam int CW  = $clog2(LEVELS + 1);
    localparam int DCW = $clog2(DEB_CYCLES + 1);
    localparam int TW  = $clog2(FILL_TIMEOUT + 1);
    localparam int OW  = $clog2(MIN_ON + 1);

    typedef enum logic [1:0] {IN_IDLE, IN_FILL, IN_FAULT} inlet_e;
    typedef enum logic [1:0] {IR_OFF, IR_DRIP, IR_SPRAY} irr_e;

    logic [NB-1:0]  sync1_q, sync2_q, filt_q;
    logic [DCW-1:0] deb_cnt_q [NB];

    // Raw vector packs {temp_hi, soil, level} so one filter bank covers every input.
    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q <= '0;
            sync2_q <= '0;
            filt_q  <= '0;
            for (int i = 0; i < NB; i++) deb_cnt_q[i] <= '0;
        end else begin
            sync1_q <= {temp_hi_i, soil_i, level_i};
            sync2_q <= sync1_q;
            for (int i = 0; i < NB; i++) begin
                if (sync2_q[i] == filt_q[i]) begin
                    deb_cnt_q[i] <= '0;
                end else if (deb_cnt_q[i] == DCW'(DEB_CYCLES - 1)) begin
                    filt_q[i]    <= sync2_q[i];
                    deb_cnt_q[i] <= '0;
                end else begin
                    deb_cnt_q[i] <= deb_cnt_q[i] + 1'b1;
                end
            end
        end
    end

    logic [LEVELS-1:0] lvl_c, lvl_p1_c;
    logic [1:0]        soil_c;
    logic              temp_c, err_lvl_c, err_soil_c, low_c;
    logic [CW-1:0]     pop_c, cnt_c;

    // A thermometer code plus one is a power of two (or wraps to zero), so the AND is empty.
    // NOTE: every always_comb output gets a default first, so no path infers a latch.
    always_comb begin
        lvl_c      = filt_q[LEVELS-1:0];
        soil_c     = filt_q[LEVELS+1:LEVELS];
        temp_c     = filt_q[LEVELS+2];
        lvl_p1_c   = lvl_c + LEVELS'(1);
        err_lvl_c  = |(lvl_c & lvl_p1_c);
        err_soil_c = (soil_c == 2'b10);
        pop_c      = '0;
        for (int i = 0; i < LEVELS; i++) pop_c = pop_c + CW'(lvl_c[i]);
        cnt_c      = err_lvl_c ? '0 : pop_c;
        low_c      = (cnt_c <= CW'(LOW_MARK));
    end

    inlet_e         inlet_q, inlet_d;
    irr_e           irr_q, irr_d;
    logic [TW-1:0]  fill_tmr_q, fill_tmr_d;
    logic [OW-1:0]  on_tmr_q, on_tmr_d;
    logic           valve_q, drip_q, spray_q, alarm_q, err_level_q, err_soil_q, fault_q;
    logic [CW-1:0]  level_count_q;
    logic           inhibit_c, spray_req_c, drip_req_c, can_leave_c;

    always_comb begin
        inlet_d    = inlet_q;
        fill_tmr_d = fill_tmr_q;
        case (inlet_q)
            IN_IDLE: begin
                if (low_c && !err_lvl_c) begin
                    inlet_d    = IN_FILL;
                    fill_tmr_d = '0;
                end
            end
            IN_FILL: begin
                // A level increase outranks a coincident timeout.
                if (err_lvl_c || cnt_c == CW'(LEVELS))    inlet_d    = IN_IDLE;
                else if (cnt_c > level_count_q)           fill_tmr_d = '0;
                else if (fill_tmr_q == TW'(FILL_TIMEOUT)) inlet_d    = IN_FAULT;
                else                                      fill_tmr_d = fill_tmr_q + 1'b1;
            end
            IN_FAULT: begin
                if (fault_clr_i) inlet_d = IN_IDLE;
            end
            default: inlet_d = IN_IDLE;
        endcase
    end

    always_comb begin
        inhibit_c   = err_lvl_c | err_soil_c | (inlet_q == IN_FAULT) | (cnt_c == '0);
        spray_req_c = !inhibit_c & ((soil_c == 2'b00) |
                      ((soil_c == 2'b01) & !temp_c & (cnt_c >= CW'(SPRAY_MIN))));
        drip_req_c  = !inhibit_c & (soil_c == 2'b01) & (temp_c | (cnt_c < CW'(SPRAY_MIN)));
        can_leave_c = (on_tmr_q >= OW'(MIN_ON - 1));
        irr_d       = irr_q;
        on_tmr_d    = on_tmr_q;
        case (irr_q)
            IR_OFF: begin
                if (spray_req_c) begin
                    irr_d    = IR_SPRAY;
                    on_tmr_d = '0;
                end else if (drip_req_c) begin
                    irr_d    = IR_DRIP;
                    on_tmr_d = '0;
                end
            end
            IR_DRIP: begin
                if (inhibit_c || (!drip_req_c && can_leave_c)) irr_d    = IR_OFF;
                else if (!can_leave_c)                         on_tmr_d = on_tmr_q + 1'b1;
            end
            IR_SPRAY: begin
                if (inhibit_c || (!spray_req_c && can_leave_c)) irr_d    = IR_OFF;
                else if (!can_leave_c)                          on_tmr_d = on_tmr_q + 1'b1;
            end
            default: irr_d = IR_OFF;
        endcase
    end

    // Outputs are decoded from next state so they change on the same edge as the FSMs.
    always_ff @(posedge clk) begin
        if (rst) begin
            inlet_q       <= IN_IDLE;
            irr_q         <= IR_OFF;
            fill_tmr_q    <= '0;
            on_tmr_q      <= '0;
            valve_q       <= 1'b0;
            drip_q        <= 1'b0;
            spray_q       <= 1'b0;
            fault_q       <= 1'b0;
            err_level_q   <= 1'b0;
            err_soil_q    <= 1'b0;
            level_count_q <= '0;
            alarm_q       <= 1'b1;
        end else begin
            inlet_q       <= inlet_d;
            irr_q         <= irr_d;
            fill_tmr_q    <= fill_tmr_d;
            on_tmr_q      <= on_tmr_d;
            valve_q       <= (inlet_d == IN_FILL);
            drip_q        <= (irr_d == IR_DRIP);
            spray_q       <= (irr_d == IR_SPRAY);
            fault_q       <= (inlet_d == IN_FAULT);
            err_level_q   <= err_lvl_c;
            err_soil_q    <= err_soil_c;
            level_count_q <= cnt_c;
            alarm_q       <= err_lvl_c | err_soil_c | (inlet_d == IN_FAULT) | low_c;
        end
    end

    assign valve_in_o    = valve_q;
    assign drip_o        = drip_q;
    assign sprinkler_o   = spray_q;
    assign alarm_o       = alarm_q;
    assign err_level_o   = err_level_q;
    assign err_soil_o    = err_soil_q;
    assign fill_fault_o  = fault_q;
    assign level_count_o = level_count_q;

endmodule
